shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Shares one Wishbone-style memory port between NUM_CORES SERV cores.
- Round-robin grant with a lock held for the whole transaction, so a grant persists until ack, error or abort.
- Per-transaction timeout protects the cores against a memory that never acks.
- Sits between the core array and the shared instruction/data memory in the GPU top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (>=1)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, maximum BUSY cycles without mem_ack before an error response (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- core_cyc  in  NUM_CORES  per-core request; held high until that core's ack
- core_we  in  NUM_CORES  per-core write enable
- core_adr  in  NUM_CORES*AW  flattened addresses; core i at [i*AW +: AW]
- core_dat  in  NUM_CORES*DW  flattened write data
- core_sel  in  NUM_CORES*DW/8  flattened byte selects
- core_ack  out  NUM_CORES  one-cycle completion pulse to the owner
- core_err  out  NUM_CORES  one-cycle timeout pulse, coincident with core_ack
- core_rdt  out  DW  read data, broadcast to all cores; valid with core_ack
- mem_cyc  out  1  memory request
- mem_we  out  1  memory write enable
- mem_adr  out  AW  memory address
- mem_dat  out  DW  memory write data
- mem_sel  out  DW/8  memory byte selects
- mem_ack  in  1  memory completion
- mem_rdt  in  DW  memory read data

Behaviour:
- Reset (synchronous, rst high at a clk edge): state=IDLE, ptr=0, owner=0, tcnt=0. While in IDLE, mem_cyc, core_ack and core_err are all 0. A reset during BUSY drops mem_cyc on the next edge and issues no ack to the owner.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If any core_cyc is high, owner <= first requester found searching upward from ptr, wrapping modulo NUM_CORES. Then state <= BUSY and tcnt <= 0.
  - mem_cyc stays 0 in IDLE, so arbitration costs exactly 1 cycle.
- BUSY:
  - mem_cyc=1. mem_we/adr/dat/sel are combinational muxes of the owner's inputs.
  - core_rdt=mem_rdt at all times.
  - core_ack[owner]=mem_ack, combinational, so memory latency passes through with no added cycle.
- Completion: on mem_ack in BUSY, state <= IDLE and ptr <= (owner+1) mod NUM_CORES.
  - Minimum back-to-back throughput is one transaction per 1+N cycles, where N is the memory latency (>=1).
- Timeout:
  - tcnt increments on each BUSY cycle without mem_ack.
  - When tcnt==TIMEOUT-1 and mem_ack=0: core_ack[owner]=1, core_err[owner]=1 and mem_cyc=0 in that cycle. Then state <= IDLE and ptr advances as for a normal completion.
  - If mem_ack and the timeout coincide, mem_ack wins and err=0.
- Abort: if core_cyc[owner] drops in BUSY without mem_ack, mem_cyc is forced 0 in that cycle, there is no ack, state <= IDLE, and ptr is unchanged.
- Requests from non-owners are ignored until the arbiter returns to IDLE; no request is lost as long as the core holds cyc.
- NUM_CORES=1: ptr and owner are 1 bit wide and held at 0. Behaviour is otherwise identical.
- Width rules:
  - ptr/owner width is max(1, $clog2(NUM_CORES)).
  - tcnt width is $clog2(TIMEOUT+1).
  - Wrap uses an explicit compare, not the % operator.

Decomposition:
- Package shared_mem_pkg:
  - arb_state_t enum {IDLE, BUSY}
  - function idx_w(n) returning max(1, $clog2(n))
- One sub-module, rr_pick:
  - Purely combinational.
  - Inputs: req vector and ptr.
  - Outputs: winner index and any_req.
  - Uses a double-width masked priority search.
  - Reused by other arbiters in the GPU.

Test Plan:
- NUM_CORES=4, cores 0 and 2 request reads, memory acks after 2 cycles -> core 0 is granted first, with core_ack[0] 3 cycles after the request; core 2 is granted next, and ptr=3 afterwards.
- All 4 cores request continuously with 1-cycle memory ack -> grant order 0,1,2,3,0 and each ack spaced 2 cycles apart.
- Core 1 writes adr=0x100, dat=0xDEADBEEF, sel=0xF -> mem_* show exactly those values for the duration of BUSY, with mem_we=1.
- TIMEOUT=4, memory never acks core 3 -> core_ack[3]=core_err[3]=1 on the 4th BUSY cycle, mem_cyc falls, and the next grant goes to core 0.
- rst asserted for one cycle mid-BUSY with core 2 owner -> mem_cyc=0 at the next edge, no core_ack, ptr=0, and core 0 wins the next arbitration.
- NUM_CORES=1, core 0 issues three reads with 2-cycle memory latency -> three acks with no error, mem_cyc low for exactly 1 cycle between transactions.

Source files
------------

// File: rtl/shared_mem_pkg.sv
// rtl/shared_mem_pkg.sv - shared types and helpers for the shared memory arbiter
package shared_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr_i, wrapping modulo N
module rr_pick
    import shared_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          any_req_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic           found;

    // The upper copy of req_i supplies the wrapped-around candidates below ptr_i.
    always_comb begin
        dbl      = {req_i, req_i};
        masked   = '0;
        winner_o = '0;
        found    = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            masked[i] = dbl[i] && (i >= int'(ptr_i));
        end
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && masked[i]) begin
                found    = 1'b1;
                winner_o = (i >= N) ? IW'(i - N) : IW'(i);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - locked round-robin arbiter sharing one memory port between cores
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      core_cyc,
    input  logic [NUM_CORES-1:0]      core_we,
    input  logic [NUM_CORES*AW-1:0]   core_adr,
    input  logic [NUM_CORES*DW-1:0]   core_dat,
    input  logic [NUM_CORES*DW/8-1:0] core_sel,
    output logic [NUM_CORES-1:0]      core_ack,
    output logic [NUM_CORES-1:0]      core_err,
    output logic [DW-1:0]             core_rdt,
    output logic                      mem_cyc,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_adr,
    output logic [DW-1:0]             mem_dat,
    output logic [DW/8-1:0]           mem_sel,
    input  logic                      mem_ack,
    input  logic [DW-1:0]             mem_rdt
);

    localparam int IW = idx_w(NUM_CORES);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = DW / 8;

    arb_state_t    state_q;
    logic [IW-1:0] ptr_q, owner_q, ptr_d, win;
    logic [TW-1:0] tcnt_q;
    logic          any_req, busy, own_cyc, tmo, done, abort;

    rr_pick #(.N(NUM_CORES), .IW(IW)) u_pick (
        .req_i     (core_cyc),
        .ptr_i     (ptr_q),
        .winner_o  (win),
        .any_req_o (any_req)
    );

    assign busy    = (state_q == BUSY);
    assign own_cyc = core_cyc[owner_q];
    assign done    = busy && mem_ack;
    assign tmo     = busy && own_cyc && !mem_ack && (tcnt_q == TW'(TIMEOUT - 1));
    assign abort   = busy && !own_cyc && !mem_ack;
    assign ptr_d   = (owner_q == IW'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;

    assign mem_cyc  = busy && own_cyc && !tmo;
    assign mem_we   = core_we[owner_q];
    assign mem_adr  = core_adr[int'(owner_q) * AW +: AW];
    assign mem_dat  = core_dat[int'(owner_q) * DW +: DW];
    assign mem_sel  = core_sel[int'(owner_q) * SW +: SW];
    assign core_rdt = mem_rdt;

    // A memory ack landing in a reset cycle is swallowed so the owner never sees it.
    always_comb begin
        core_ack = '0;
        core_err = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (owner_q == IW'(i) && !rst) begin
                core_ack[i] = done || tmo;
                core_err[i] = tmo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            tcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= win;
                        tcnt_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (done || tmo) begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_d;
                    end else if (abort) begin
                        state_q <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - directed self-checking bench for shared_mem_arbiter
module tb_shared_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic         rst;
    logic [3:0]   core_cyc, core_we, core_ack, core_err;
    logic [127:0] core_adr, core_dat;
    logic [15:0]  core_sel;
    logic [31:0]  core_rdt, mem_adr, mem_dat, mem_rdt;
    logic [3:0]   mem_sel;
    logic         mem_cyc, mem_we;
    logic         mem_ack = 1'b0;
    logic         mem_en  = 1'b0;
    int           lat     = 1;
    int           mcnt    = 0;

    logic         s_cyc, s_we, s_ack, s_err, s_mcyc, s_mwe;
    logic [31:0]  s_adr, s_dat, s_rdt, s_madr, s_mdat, s_mrdt;
    logic [3:0]   s_sel, s_msel;
    logic         s_mack = 1'b0;
    logic         s_en   = 1'b0;
    int           s_lat  = 1;
    int           s_mcnt = 0;

    assign mem_rdt = mem_adr ^ 32'h5A5A_0000;
    assign s_mrdt  = s_madr ^ 32'h5A5A_0000;

    shared_mem_arbiter #(.NUM_CORES(4), .AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .core_cyc(core_cyc), .core_we(core_we), .core_adr(core_adr),
        .core_dat(core_dat), .core_sel(core_sel),
        .core_ack(core_ack), .core_err(core_err), .core_rdt(core_rdt),
        .mem_cyc(mem_cyc), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_dat(mem_dat), .mem_sel(mem_sel),
        .mem_ack(mem_ack), .mem_rdt(mem_rdt)
    );

    shared_mem_arbiter #(.NUM_CORES(1), .AW(32), .DW(32), .TIMEOUT(255)) dut1 (
        .clk(clk), .rst(rst),
        .core_cyc(s_cyc), .core_we(s_we), .core_adr(s_adr),
        .core_dat(s_dat), .core_sel(s_sel),
        .core_ack(s_ack), .core_err(s_err), .core_rdt(s_rdt),
        .mem_cyc(s_mcyc), .mem_we(s_mwe), .mem_adr(s_madr),
        .mem_dat(s_mdat), .mem_sel(s_msel),
        .mem_ack(s_mack), .mem_rdt(s_mrdt)
    );

    // Memory with fixed latency: acks in the lat-th consecutive cycle of mem_cyc.
    always begin
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        #1;
        if (mem_en && mem_cyc) begin
            if (mcnt == lat - 1) begin
                mem_ack = 1'b1;
                mcnt    = 0;
            end else begin
                mcnt++;
            end
        end else begin
            mcnt = 0;
        end
    end

    always begin
        @(posedge clk);
        #1;
        s_mack = 1'b0;
        #1;
        if (s_en && s_mcyc) begin
            if (s_mcnt == s_lat - 1) begin
                s_mack = 1'b1;
                s_mcnt = 0;
            end else begin
                s_mcnt++;
            end
        end else begin
            s_mcnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #5;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        core_cyc = 4'h0;
        core_we  = 4'h0;
        mem_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        core_cyc = 4'hF;
        s_cyc    = 1'b1;
        tick();
        tick();
        total++;
        if ({mem_cyc, core_ack, core_err} !== 9'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", {mem_cyc, core_ack, core_err}, 9'h000);
        end
        total++;
        if ({s_mcyc, s_ack, s_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_single got=%b want=000", {s_mcyc, s_ack, s_err});
        end
        core_cyc = 4'h0;
        s_cyc    = 1'b0;
        rst      = 1'b0;
        tick();
        total++;
        if ({mem_cyc, core_ack, core_err} !== 9'h000) begin
            bad++;
            $display("FAIL idle_outputs got=%h want=%h", {mem_cyc, core_ack, core_err}, 9'h000);
        end
    endtask

    task automatic test_two_reqs();
        do_reset();
        core_adr[0*32 +: 32] = 32'h10;
        core_adr[2*32 +: 32] = 32'h20;
        core_adr[3*32 +: 32] = 32'h30;
        lat      = 2;
        mem_en   = 1'b1;
        core_cyc = 4'b0101;
        tick();
        total++;
        if ({mem_cyc, core_ack, mem_adr} !== {1'b1, 4'h0, 32'h10}) begin
            bad++;
            $display("FAIL two_busy1 got=%h want=%h", {mem_cyc, core_ack, mem_adr}, {1'b1, 4'h0, 32'h10});
        end
        tick();
        total++;
        if ({core_ack, core_rdt} !== {4'b0001, 32'h5A5A_0010}) begin
            bad++;
            $display("FAIL two_ack0 got=%h want=%h", {core_ack, core_rdt}, {4'b0001, 32'h5A5A_0010});
        end
        tick();
        total++;
        if (mem_cyc !== 1'b0) begin
            bad++;
            $display("FAIL two_idle_gap got=%b want=0", mem_cyc);
        end
        core_cyc = 4'b0100;
        tick();
        total++;
        if ({mem_cyc, mem_adr} !== {1'b1, 32'h20}) begin
            bad++;
            $display("FAIL two_grant2 got=%h want=%h", {mem_cyc, mem_adr}, {1'b1, 32'h20});
        end
        tick();
        total++;
        if (core_ack !== 4'b0100) begin
            bad++;
            $display("FAIL two_ack2 got=%b want=0100", core_ack);
        end
        tick();
        core_cyc = 4'b1001;
        tick();
        total++;
        if ({mem_cyc, mem_adr} !== {1'b1, 32'h30}) begin
            bad++;
            $display("FAIL two_ptr3 got=%h want=%h", {mem_cyc, mem_adr}, {1'b1, 32'h30});
        end
        tick();
        total++;
        if (core_ack !== 4'b1000) begin
            bad++;
            $display("FAIL two_ack3 got=%b want=1000", core_ack);
        end
        core_cyc = 4'h0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) core_adr[i*32 +: 32] = 32'h40 * (i + 1);
        lat      = 1;
        mem_en   = 1'b1;
        core_cyc = 4'hF;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp = 4'h0;
            if (c % 2 == 1) exp[((c - 1) / 2) % 4] = 1'b1;
            total++;
            if (core_ack !== exp) begin
                bad++;
                $display("FAIL rr_cycle%0d got=%b want=%b", c, core_ack, exp);
            end
        end
        core_cyc = 4'h0;
        tick();
    endtask

    task automatic test_write_mux();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_adr[i*32 +: 32] = 32'h1000 + i;
            core_dat[i*32 +: 32] = 32'h1111_1111 * i;
        end
        core_sel             = 16'h1234;
        core_adr[1*32 +: 32] = 32'h100;
        core_dat[1*32 +: 32] = 32'hDEAD_BEEF;
        core_sel[7:4]        = 4'hF;
        core_we              = 4'b0010;
        lat                  = 3;
        mem_en               = 1'b1;
        core_cyc             = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if ({mem_cyc, mem_we, mem_adr, mem_dat, mem_sel} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF}) begin
                bad++;
                $display("FAIL wr_mux_cycle%0d got=%h want=%h", c,
                         {mem_cyc, mem_we, mem_adr, mem_dat, mem_sel},
                         {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF});
            end
        end
        total++;
        if (core_ack !== 4'b0010) begin
            bad++;
            $display("FAIL wr_ack got=%b want=0010", core_ack);
        end
        core_cyc = 4'h0;
        core_we  = 4'h0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        core_adr[0*32 +: 32] = 32'h40;
        core_adr[3*32 +: 32] = 32'h70;
        mem_en   = 1'b0;
        core_cyc = 4'b1000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            total++;
            if ({mem_cyc, core_ack, core_err} !== {1'b1, 8'h00}) begin
                bad++;
                $display("FAIL tmo_wait%0d got=%h want=%h", c, {mem_cyc, core_ack, core_err}, {1'b1, 8'h00});
            end
        end
        tick();
        total++;
        if ({mem_cyc, core_ack, core_err} !== {1'b0, 4'b1000, 4'b1000}) begin
            bad++;
            $display("FAIL tmo_fire got=%h want=%h", {mem_cyc, core_ack, core_err}, {1'b0, 4'b1000, 4'b1000});
        end
        core_cyc = 4'b1001;
        tick();
        mem_en = 1'b1;
        lat    = 1;
        total++;
        if (mem_cyc !== 1'b0) begin
            bad++;
            $display("FAIL tmo_idle got=%b want=0", mem_cyc);
        end
        tick();
        total++;
        if ({mem_cyc, mem_adr, core_ack, core_err} !== {1'b1, 32'h40, 4'b0001, 4'b0000}) begin
            bad++;
            $display("FAIL tmo_next_grant got=%h want=%h", {mem_cyc, mem_adr, core_ack, core_err},
                     {1'b1, 32'h40, 4'b0001, 4'b0000});
        end
        core_cyc = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        core_adr[0*32 +: 32] = 32'h40;
        core_adr[1*32 +: 32] = 32'h50;
        core_adr[2*32 +: 32] = 32'h60;
        lat      = 1;
        mem_en   = 1'b1;
        core_cyc = 4'b0010;
        tick();
        total++;
        if (core_ack !== 4'b0010) begin
            bad++;
            $display("FAIL rstb_ack1 got=%b want=0010", core_ack);
        end
        core_cyc = 4'b0100;
        mem_en   = 1'b0;
        tick();
        tick();
        total++;
        if ({mem_cyc, mem_adr} !== {1'b1, 32'h60}) begin
            bad++;
            $display("FAIL rstb_owner2 got=%h want=%h", {mem_cyc, mem_adr}, {1'b1, 32'h60});
        end
        rst      = 1'b1;
        core_cyc = 4'b0101;
        tick();
        rst = 1'b0;
        total++;
        if ({mem_cyc, core_ack, core_err} !== 9'h000) begin
            bad++;
            $display("FAIL rstb_dropped got=%h want=%h", {mem_cyc, core_ack, core_err}, 9'h000);
        end
        tick();
        total++;
        if ({mem_cyc, mem_adr} !== {1'b1, 32'h40}) begin
            bad++;
            $display("FAIL rstb_regrant got=%h want=%h", {mem_cyc, mem_adr}, {1'b1, 32'h40});
        end
        core_cyc = 4'h0;
        tick();
    endtask

    task automatic test_single_core();
        logic [2:0] exp_tab [9] = '{3'b100, 3'b110, 3'b000, 3'b100, 3'b110,
                                    3'b000, 3'b100, 3'b110, 3'b000};
        s_adr = 32'h80;
        s_we  = 1'b0;
        s_lat = 2;
        s_en  = 1'b1;
        s_cyc = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            total++;
            if ({s_mcyc, s_ack, s_err} !== exp_tab[c-1]) begin
                bad++;
                $display("FAIL single_cycle%0d got=%b want=%b", c, {s_mcyc, s_ack, s_err}, exp_tab[c-1]);
            end
            if (c == 2) begin
                total++;
                if (s_rdt !== 32'h5A5A_0080) begin
                    bad++;
                    $display("FAIL single_rdt got=%h want=%h", s_rdt, 32'h5A5A_0080);
                end
            end
            if (c == 8) s_cyc = 1'b0;
        end
        s_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        core_cyc = 4'h0;
        core_we  = 4'h0;
        core_adr = '0;
        core_dat = '0;
        core_sel = '0;
        s_cyc    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat    = 32'h0;
        s_sel    = 4'hF;
        test_reset();
        test_two_reqs();
        test_round_robin();
        test_write_mux();
        test_timeout();
        test_reset_mid_busy();
        test_single_core();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
